can_tx_mailbox_ctrl: RTL and testbench
======================================

// Module: can_tx_mailbox_ctrl
// PURPOSE
//  Multi-mailbox transmit scheduler placed in front of can_transmitter. It generalises the
//  single-frame start_tx interface to NUM_MB buffered frames and picks the pending frame with
//  the highest CAN arbitration priority. It retries after arbitration loss or error, and
//  supports per-mailbox abort with ok/fail status.
// PARAMETERS
//  NUM_MB     4  number of transmit mailboxes (2..32)
//  MAX_RETRY  0  error retries per frame before fail; 0 = retry forever
//  IDX_W      $clog2(NUM_MB)  derived; mailbox index width
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  mb_wr_en     in   1       load the mailbox at mb_wr_idx
//  mb_wr_idx    in   IDX_W   target mailbox
//  mb_wr_ide    in   1       0 = standard id[10:0]; 1 = extended id[28:0], base = id[28:18]
//  mb_wr_id     in   29      identifier
//  mb_wr_rtr    in   1       remote frame
//  mb_wr_dlc    in   4       data length code
//  mb_wr_data   in   64      payload; byte k is [8k+7:8k]
//  mb_req       in   NUM_MB  per-bit pulse: request transmission
//  mb_abort     in   NUM_MB  per-bit pulse: abort request
//  bus_idle     in   1       bus idle / intermission complete; transmission may start
//  tx_done      in   1       pulse: active frame sent and acknowledged
//  arb_lost     in   1       pulse: active frame lost arbitration
//  tx_error     in   1       pulse: error frame during active frame
//  start_tx     out  1       one-cycle start pulse to can_transmitter
//  ide,rtr      out  1       active frame fields
//  id_std       out  11      ide ? id[28:18] : id[10:0]
//  id_ext       out  29      id
//  dlc          out  4       active dlc
//  tx_data_0..7 out  8 each  active payload bytes
//  mb_pending   out  NUM_MB  request outstanding
//  tx_ok        out  NUM_MB  one-cycle pulse: mailbox sent
//  tx_fail      out  NUM_MB  one-cycle pulse: mailbox aborted or retries exhausted
//  tx_busy      out  1       FSM outside IDLE
// BEHAVIOUR
//  Reset: all outputs 0, pending/retry counters 0, mailbox storage 0, FSM = IDLE. Reset takes
//   effect immediately, including mid-frame; start_tx is never re-issued after reset.
//  Write: mb_wr_en loads storage at the next edge. A write to a pending mailbox is ignored.
//   Write and mb_req on the same index in the same cycle: the new data is sent.
//  mb_req sets pending at the next edge; a request to an already pending mailbox has no effect.
//  Priority key (32b, lower wins) = {base11, ide ? 1 : rtr, ide, ide ? id[17:0] : 18'h0,
//   ide ? rtr : 0}. Equal keys: lowest index wins.
//  FSM
//   IDLE:  if any pending, go to SELECT.
//   SELECT: latch winner index and frame into the active register; outputs come from that
//    register and stay frozen until IDLE. Go to WAIT.
//   WAIT:  if bus_idle, go to START. If the active mailbox is aborted, fail and go to IDLE.
//   START: start_tx = 1 for this one cycle; go to BUSY.
//   BUSY:  wait for an outcome pulse; outcome priority is tx_done > tx_error > arb_lost.
//    tx_done:  clear pending, tx_ok pulse, clear retry counter, go to IDLE.
//    arb_lost: counter unchanged; go to IDLE, where a new selection may pick another mailbox.
//    tx_error: counter += 1. If MAX_RETRY != 0 and counter == MAX_RETRY: clear pending,
//     tx_fail pulse, clear counter. Go to IDLE.
//  Latency: mb_req at edge n -> pending n+1 -> SELECT n+2 -> START n+4 (bus_idle held).
//  Abort
//   Non-active mailbox: clear pending and pulse tx_fail at the next edge.
//   Active mailbox in BUSY: deferred. tx_done -> tx_ok; any other outcome -> tx_fail.
//   Abort of a non-pending mailbox: ignored.
//   Abort and req on the same bit in the same cycle: abort wins and the mailbox stays idle.
//  Retry counter: width $clog2(MAX_RETRY+1), minimum 1 bit. With MAX_RETRY=0 it saturates
//   and never fails.
// STRUCTURE
//  can_pkg holds can_frame_t (ide, id[28:0], rtr, dlc, data[63:0]), the tx_mb_state_e enum,
//   and the function arb_key(can_frame_t) -> logic[31:0].
//  Sub-module can_mb_prio_sel: combinational min-key finder over NUM_MB keys, masked by
//   pending. Outputs are the winner index and a valid flag.
// TESTING
//  1. Single mailbox: load MB0 (std 0x123, dlc 2, 0xAA55), req, bus_idle=1 -> start_tx at n+4,
//     id_std=0x123; tx_done -> tx_ok[0], pending 0.
//  2. Priority: MB1 std 0x100, MB2 std 0x0FF, MB3 ext base 0x0FF -> send order MB2, MB3, MB1.
//  3. arb_lost on MB1 while MB0 (id 0x010) is requested mid-frame -> next start_tx uses
//     MB0; MB1 is sent afterwards and its retry counter stays 0.
//  4. MAX_RETRY=3: three tx_error pulses -> tx_fail[0] after the third, no fourth start_tx.
//  5. Abort MB2 while pending, not active -> tx_fail[2] next cycle. Abort the active MB
//     then tx_done -> tx_ok only.
//  6. rst_n low during BUSY -> all outputs 0 immediately; no start_tx after release.

Source files
------------

// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared frame type, scheduler states and arbitration key
package can_pkg;

    localparam int KEY_W = 32;

    typedef struct packed {
        logic        ide;
        logic [28:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_frame_t;

    typedef enum logic [2:0] {
        MB_IDLE,
        MB_SELECT,
        MB_WAIT,
        MB_START,
        MB_BUSY
    } tx_mb_state_e;

    // Key mirrors the on-wire arbitration field order so a numeric compare
    // reproduces bus priority: base id, SRR/RTR, IDE, id extension, RTR.
    function automatic logic [KEY_W-1:0] arb_key(input can_frame_t f);
        logic [10:0] base;
        base = f.ide ? f.id[28:18] : f.id[10:0];
        return {base,
                f.ide ? 1'b1 : f.rtr,
                f.ide,
                f.ide ? f.id[17:0] : 18'h0,
                f.ide ? f.rtr : 1'b0};
    endfunction

endpackage

// File: rtl/can_mb_prio_sel.sv
// rtl/can_mb_prio_sel.sv - minimum-key finder over the pending mailboxes
module can_mb_prio_sel
    import can_pkg::*;
#(
    parameter int  NUM_MB = 4,
    localparam int IDX_W  = $clog2(NUM_MB)
) (
    input  logic [NUM_MB*KEY_W-1:0] keys_i,
    input  logic [NUM_MB-1:0]       mask_i,
    output logic [IDX_W-1:0]        win_idx_o,
    output logic                    win_valid_o
);

    logic [KEY_W-1:0] best_key;

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        win_idx_o   = '0;
        win_valid_o = 1'b0;
        best_key    = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (mask_i[i] && (!win_valid_o || keys_i[i*KEY_W +: KEY_W] < best_key)) begin
                win_valid_o = 1'b1;
                best_key    = keys_i[i*KEY_W +: KEY_W];
                win_idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/can_tx_mailbox_ctrl.sv
// rtl/can_tx_mailbox_ctrl.sv - multi-mailbox CAN transmit scheduler with retry and abort
module can_tx_mailbox_ctrl
    import can_pkg::*;
#(
    parameter int  NUM_MB    = 4,
    parameter int  MAX_RETRY = 0,
    localparam int IDX_W     = $clog2(NUM_MB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mb_wr_en,
    input  logic [IDX_W-1:0]  mb_wr_idx,
    input  logic              mb_wr_ide,
    input  logic [28:0]       mb_wr_id,
    input  logic              mb_wr_rtr,
    input  logic [3:0]        mb_wr_dlc,
    input  logic [63:0]       mb_wr_data,
    input  logic [NUM_MB-1:0] mb_req,
    input  logic [NUM_MB-1:0] mb_abort,
    input  logic              bus_idle,
    input  logic              tx_done,
    input  logic              arb_lost,
    input  logic              tx_error,
    output logic              start_tx,
    output logic              ide,
    output logic              rtr,
    output logic [10:0]       id_std,
    output logic [28:0]       id_ext,
    output logic [3:0]        dlc,
    output logic [7:0]        tx_data_0,
    output logic [7:0]        tx_data_1,
    output logic [7:0]        tx_data_2,
    output logic [7:0]        tx_data_3,
    output logic [7:0]        tx_data_4,
    output logic [7:0]        tx_data_5,
    output logic [7:0]        tx_data_6,
    output logic [7:0]        tx_data_7,
    output logic [NUM_MB-1:0] mb_pending,
    output logic [NUM_MB-1:0] tx_ok,
    output logic [NUM_MB-1:0] tx_fail,
    output logic              tx_busy
);

    localparam int RW_RAW = $clog2(MAX_RETRY + 1);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    can_frame_t               frames_q [NUM_MB];
    can_frame_t               wr_frame;
    logic [NUM_MB*KEY_W-1:0]  keys;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_valid;

    tx_mb_state_e             state_q;
    logic [IDX_W-1:0]         act_idx_q;
    can_frame_t               act_frame_q;
    logic                     start_tx_q;
    logic                     abort_q;

    logic [NUM_MB-1:0]        pending_q, pending_d;
    logic [NUM_MB-1:0]        tx_ok_q, tx_ok_d;
    logic [NUM_MB-1:0]        tx_fail_q, tx_fail_d;
    logic [RW-1:0]            retry_q [NUM_MB];
    logic [RW-1:0]            retry_d [NUM_MB];
    logic [RW-1:0]            retry_inc;
    logic                     locked;
    logic                     outcome;
    logic                     act_abort;

    assign wr_frame = '{ide: mb_wr_ide, id: mb_wr_id, rtr: mb_wr_rtr,
                        dlc: mb_wr_dlc, data: mb_wr_data};

    // Mailbox storage; a pending mailbox is write-protected so the queued frame cannot change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MB; i++) frames_q[i] <= '0;
        end else if (mb_wr_en && !pending_q[mb_wr_idx]) begin
            frames_q[mb_wr_idx] <= wr_frame;
        end
    end

    // Arbitration keys of every stored frame.
    always_comb begin
        keys = '0;
        for (int i = 0; i < NUM_MB; i++) keys[i*KEY_W +: KEY_W] = arb_key(frames_q[i]);
    end

    can_mb_prio_sel #(.NUM_MB(NUM_MB)) u_prio_sel (
        .keys_i      (keys),
        .mask_i      (pending_q),
        .win_idx_o   (sel_idx),
        .win_valid_o (sel_valid)
    );

    // Pending, retry and status bookkeeping; the active mailbox is locked once START is reached.
    always_comb begin
        pending_d = pending_q;
        tx_ok_d   = '0;
        tx_fail_d = '0;
        retry_d   = retry_q;
        locked    = (state_q == MB_START) || (state_q == MB_BUSY);
        outcome   = (state_q == MB_BUSY) && (tx_done || tx_error || arb_lost);
        act_abort = abort_q || mb_abort[act_idx_q];
        retry_inc = (retry_q[act_idx_q] == '1) ? retry_q[act_idx_q] : retry_q[act_idx_q] + 1'b1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (mb_abort[i] && pending_q[i] && !(locked && (IDX_W'(i) == act_idx_q))) begin
                pending_d[i] = 1'b0;
                tx_fail_d[i] = 1'b1;
                retry_d[i]   = '0;
            end else if (mb_req[i] && !mb_abort[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
            end
        end
        if (outcome) begin
            if (tx_done) begin
                pending_d[act_idx_q] = 1'b0;
                tx_ok_d[act_idx_q]   = 1'b1;
                retry_d[act_idx_q]   = '0;
            end else if (act_abort ||
                         (tx_error && (MAX_RETRY != 0) && (retry_inc == RETRY_LIMIT))) begin
                pending_d[act_idx_q] = 1'b0;
                tx_fail_d[act_idx_q] = 1'b1;
                retry_d[act_idx_q]   = '0;
            end else if (tx_error) begin
                retry_d[act_idx_q]   = retry_inc;
            end
        end
    end

    // Register the bookkeeping state and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            tx_ok_q   <= '0;
            tx_fail_q <= '0;
            for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            tx_ok_q   <= tx_ok_d;
            tx_fail_q <= tx_fail_d;
            retry_q   <= retry_d;
        end
    end

    // Scheduler FSM: choose, wait for the bus, kick the transmitter, await the outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MB_IDLE;
            act_idx_q   <= '0;
            act_frame_q <= '0;
            start_tx_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            start_tx_q <= 1'b0;
            case (state_q)
                MB_IDLE: begin
                    if (|pending_q) state_q <= MB_SELECT;
                end
                MB_SELECT: begin
                    if (sel_valid) begin
                        act_idx_q   <= sel_idx;
                        act_frame_q <= frames_q[sel_idx];
                        abort_q     <= 1'b0;
                        state_q     <= MB_WAIT;
                    end else begin
                        state_q <= MB_IDLE;
                    end
                end
                MB_WAIT: begin
                    // Pending may have been cleared by an abort landing in SELECT.
                    if (mb_abort[act_idx_q] || !pending_q[act_idx_q]) begin
                        state_q <= MB_IDLE;
                    end else if (bus_idle) begin
                        state_q    <= MB_START;
                        start_tx_q <= 1'b1;
                    end
                end
                MB_START: begin
                    state_q <= MB_BUSY;
                    if (mb_abort[act_idx_q]) abort_q <= 1'b1;
                end
                MB_BUSY: begin
                    if (outcome) begin
                        state_q <= MB_IDLE;
                        abort_q <= 1'b0;
                    end else if (mb_abort[act_idx_q]) begin
                        abort_q <= 1'b1;
                    end
                end
                default: state_q <= MB_IDLE;
            endcase
        end
    end

    assign start_tx   = start_tx_q;
    assign tx_busy    = (state_q != MB_IDLE);
    assign mb_pending = pending_q;
    assign tx_ok      = tx_ok_q;
    assign tx_fail    = tx_fail_q;
    assign ide        = act_frame_q.ide;
    assign rtr        = act_frame_q.rtr;
    assign id_ext     = act_frame_q.id;
    assign id_std     = act_frame_q.ide ? act_frame_q.id[28:18] : act_frame_q.id[10:0];
    assign dlc        = act_frame_q.dlc;
    assign tx_data_0  = act_frame_q.data[7:0];
    assign tx_data_1  = act_frame_q.data[15:8];
    assign tx_data_2  = act_frame_q.data[23:16];
    assign tx_data_3  = act_frame_q.data[31:24];
    assign tx_data_4  = act_frame_q.data[39:32];
    assign tx_data_5  = act_frame_q.data[47:40];
    assign tx_data_6  = act_frame_q.data[55:48];
    assign tx_data_7  = act_frame_q.data[63:56];

endmodule

// File: tb/tb_can_tx_mailbox_ctrl.sv
// tb/tb_can_tx_mailbox_ctrl.sv - directed self-checking bench for can_tx_mailbox_ctrl
module tb_can_tx_mailbox_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mb_wr_en;
    logic [1:0]  mb_wr_idx;
    logic        mb_wr_ide;
    logic [28:0] mb_wr_id;
    logic        mb_wr_rtr;
    logic [3:0]  mb_wr_dlc;
    logic [63:0] mb_wr_data;
    logic [3:0]  mb_req;
    logic [3:0]  mb_abort;
    logic        bus_idle;
    logic        tx_done;
    logic        arb_lost;
    logic        tx_error;
    logic        start_tx;
    logic        ide;
    logic        rtr;
    logic [10:0] id_std;
    logic [28:0] id_ext;
    logic [3:0]  dlc;
    logic [7:0]  tx_data_0, tx_data_1, tx_data_2, tx_data_3;
    logic [7:0]  tx_data_4, tx_data_5, tx_data_6, tx_data_7;
    logic [3:0]  mb_pending;
    logic [3:0]  tx_ok;
    logic [3:0]  tx_fail;
    logic        tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    can_tx_mailbox_ctrl #(.NUM_MB(4), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .mb_wr_en(mb_wr_en), .mb_wr_idx(mb_wr_idx), .mb_wr_ide(mb_wr_ide),
        .mb_wr_id(mb_wr_id), .mb_wr_rtr(mb_wr_rtr), .mb_wr_dlc(mb_wr_dlc),
        .mb_wr_data(mb_wr_data), .mb_req(mb_req), .mb_abort(mb_abort),
        .bus_idle(bus_idle), .tx_done(tx_done), .arb_lost(arb_lost), .tx_error(tx_error),
        .start_tx(start_tx), .ide(ide), .rtr(rtr), .id_std(id_std), .id_ext(id_ext),
        .dlc(dlc), .tx_data_0(tx_data_0), .tx_data_1(tx_data_1), .tx_data_2(tx_data_2),
        .tx_data_3(tx_data_3), .tx_data_4(tx_data_4), .tx_data_5(tx_data_5),
        .tx_data_6(tx_data_6), .tx_data_7(tx_data_7), .mb_pending(mb_pending),
        .tx_ok(tx_ok), .tx_fail(tx_fail), .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_idx;
        logic [28:0] wr_id;
        logic [3:0]  req;
        logic [3:0]  abort;
        logic        bus_idle;
        logic        done;
        logic        e_start;
        logic [3:0]  e_pend;
        logic [3:0]  e_ok;
        logic [3:0]  e_fail;
        logic        e_busy;
        logic [10:0] e_id;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] idx, input logic x_ide, input logic [28:0] id);
        mb_wr_en   = 1'b1;
        mb_wr_idx  = idx;
        mb_wr_ide  = x_ide;
        mb_wr_id   = id;
        mb_wr_dlc  = 4'd1;
        mb_wr_data = 64'h77;
        step();
        mb_wr_en   = 1'b0;
    endtask

    task automatic pulse_req(input logic [3:0] r);
        mb_req = r;
        step();
        mb_req = 4'b0;
    endtask

    // Waits for start_tx, then advances one cycle so the FSM sits in BUSY.
    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (start_tx !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        check(name, {31'b0, start_tx}, 32'd1);
        step();
    endtask

    task automatic outcome(input logic d, input logic e, input logic l);
        tx_done  = d;
        tx_error = e;
        arb_lost = l;
        step();
        tx_done  = 1'b0;
        tx_error = 1'b0;
        arb_lost = 1'b0;
    endtask

    logic [10:0] t2_id  [3];
    logic        t2_ide [3];
    logic [3:0]  t2_ok  [3];
    int          starts;

    initial begin
        rst_n = 1'b0; mb_wr_en = 1'b0; mb_wr_idx = '0; mb_wr_ide = 1'b0; mb_wr_id = '0;
        mb_wr_rtr = 1'b0; mb_wr_dlc = '0; mb_wr_data = '0; mb_req = '0; mb_abort = '0;
        bus_idle = 1'b0; tx_done = 1'b0; arb_lost = 1'b0; tx_error = 1'b0;

        //            wr   idx    id       req      abort    bi    dn    st    pend     ok       fail     busy  id
        vecs[0]  = '{1'b1, 2'd0, 29'h123, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 11'h000};
        vecs[1]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 11'h000};
        vecs[2]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 11'h123};
        vecs[3]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 11'h123};
        vecs[4]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 11'h123};
        vecs[5]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 11'h123};
        vecs[6]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 11'h123};
        vecs[7]  = '{1'b1, 2'd1, 29'h200, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 11'h123};
        vecs[8]  = '{1'b1, 2'd2, 29'h300, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 4'b0000, 1'b1, 11'h123};
        vecs[9]  = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0100, 1'b1, 11'h200};
        vecs[10] = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 11'h200};
        vecs[11] = '{1'b0, 2'd0, 29'h000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 11'h200};
        vecs[12] = '{1'b0, 2'd0, 29'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 11'h200};

        t2_id[0] = 11'h0FF; t2_ide[0] = 1'b0; t2_ok[0] = 4'b0100;
        t2_id[1] = 11'h0FF; t2_ide[1] = 1'b1; t2_ok[1] = 4'b1000;
        t2_id[2] = 11'h100; t2_ide[2] = 1'b0; t2_ok[2] = 4'b0010;

        repeat (3) step();
        check("reset_start", {31'b0, start_tx}, 32'd0);
        check("reset_busy", {31'b0, tx_busy}, 32'd0);
        check("reset_pending", {28'b0, mb_pending}, 32'd0);
        check("reset_id_ext", {3'b0, id_ext}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single mailbox flow, latency, abort in non-locked states, abort-beats-req
        mb_wr_ide = 1'b0; mb_wr_rtr = 1'b0; mb_wr_dlc = 4'd2; mb_wr_data = 64'hAA55;
        for (int v = 0; v < NV; v++) begin
            mb_wr_en  = vecs[v].wr_en;
            mb_wr_idx = vecs[v].wr_idx;
            mb_wr_id  = vecs[v].wr_id;
            mb_req    = vecs[v].req;
            mb_abort  = vecs[v].abort;
            bus_idle  = vecs[v].bus_idle;
            tx_done   = vecs[v].done;
            step();
            check($sformatf("v%0d_start", v), {31'b0, start_tx}, {31'b0, vecs[v].e_start});
            check($sformatf("v%0d_pending", v), {28'b0, mb_pending}, {28'b0, vecs[v].e_pend});
            check($sformatf("v%0d_ok", v), {28'b0, tx_ok}, {28'b0, vecs[v].e_ok});
            check($sformatf("v%0d_fail", v), {28'b0, tx_fail}, {28'b0, vecs[v].e_fail});
            check($sformatf("v%0d_busy", v), {31'b0, tx_busy}, {31'b0, vecs[v].e_busy});
            check($sformatf("v%0d_id_std", v), {21'b0, id_std}, {21'b0, vecs[v].e_id});
            check($sformatf("v%0d_dlc_data", v), {12'b0, dlc, tx_data_1, tx_data_0},
                  (vecs[v].e_id == 11'h0) ? 32'h0 : {12'b0, 4'd2, 16'hAA55});
        end
        mb_wr_en = 1'b0; mb_req = '0; mb_abort = '0; tx_done = 1'b0;

        // Priority order: std 0x0FF, ext base 0x0FF, std 0x100
        bus_idle = 1'b0;
        load(2'd1, 1'b0, 29'h100);
        load(2'd2, 1'b0, 29'h0FF);
        load(2'd3, 1'b1, {11'h0FF, 18'h00001});
        pulse_req(4'b1110);
        bus_idle = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start($sformatf("t2_start%0d", k));
            check($sformatf("t2_id%0d", k), {21'b0, id_std}, {21'b0, t2_id[k]});
            check($sformatf("t2_ide%0d", k), {31'b0, ide}, {31'b0, t2_ide[k]});
            outcome(1'b1, 1'b0, 1'b0);
            check($sformatf("t2_ok%0d", k), {28'b0, tx_ok}, {28'b0, t2_ok[k]});
        end

        // Arbitration loss lets a higher-priority newcomer go first; no retry charge
        load(2'd1, 1'b0, 29'h100);
        pulse_req(4'b0010);
        wait_start("t3_start_mb1");
        check("t3_id_mb1", {21'b0, id_std}, 32'h100);
        load(2'd0, 1'b0, 29'h010);
        pulse_req(4'b0001);
        outcome(1'b0, 1'b0, 1'b1);
        check("t3_lost_status", {24'b0, tx_ok, tx_fail}, 32'h0);
        check("t3_lost_pending", {28'b0, mb_pending}, 32'b0011);
        wait_start("t3_start_mb0");
        check("t3_id_mb0", {21'b0, id_std}, 32'h010);
        outcome(1'b1, 1'b0, 1'b0);
        check("t3_ok_mb0", {28'b0, tx_ok}, 32'b0001);
        for (int k = 0; k < 2; k++) begin
            wait_start($sformatf("t3_retry_start%0d", k));
            check($sformatf("t3_retry_id%0d", k), {21'b0, id_std}, 32'h100);
            outcome(1'b0, 1'b1, 1'b0);
            check($sformatf("t3_retry_fail%0d", k), {28'b0, tx_fail}, 32'b0);
        end
        wait_start("t3_final_start");
        outcome(1'b1, 1'b0, 1'b0);
        check("t3_final_ok", {28'b0, tx_ok}, 32'b0010);
        check("t3_final_fail", {28'b0, tx_fail}, 32'b0);

        // Retry limit of three errors
        load(2'd0, 1'b0, 29'h055);
        pulse_req(4'b0001);
        for (int k = 0; k < 3; k++) begin
            wait_start($sformatf("t4_start%0d", k));
            outcome(1'b0, 1'b1, 1'b0);
            check($sformatf("t4_fail%0d", k), {28'b0, tx_fail}, (k == 2) ? 32'b0001 : 32'b0);
        end
        starts = 0;
        repeat (20) begin
            step();
            if (start_tx === 1'b1) starts++;
        end
        check("t4_no_fourth_start", starts, 0);
        check("t4_pending", {28'b0, mb_pending}, 32'b0);

        // Deferred abort of the active mailbox, then successful send
        load(2'd2, 1'b0, 29'h222);
        pulse_req(4'b0100);
        wait_start("t5_start");
        mb_abort = 4'b0100;
        step();
        mb_abort = 4'b0;
        check("t5_deferred_fail", {28'b0, tx_fail}, 32'b0);
        check("t5_deferred_pending", {28'b0, mb_pending}, 32'b0100);
        repeat (3) step();
        outcome(1'b1, 1'b0, 1'b0);
        check("t5_ok", {28'b0, tx_ok}, 32'b0100);
        check("t5_no_fail", {28'b0, tx_fail}, 32'b0);

        // Reset in the middle of a frame
        load(2'd0, 1'b0, 29'h321);
        pulse_req(4'b0001);
        wait_start("t6_start");
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'b0, tx_busy}, 32'd0);
        check("t6_rst_pending", {28'b0, mb_pending}, 32'd0);
        check("t6_rst_id", {21'b0, id_std}, 32'd0);
        check("t6_rst_start", {31'b0, start_tx}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        starts = 0;
        repeat (20) begin
            step();
            if (start_tx === 1'b1) starts++;
        end
        check("t6_no_restart", starts, 0);
        check("t6_busy_after", {31'b0, tx_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
